// File: rtl/hub_xfer.sv
// Requester-side engine for the hub memory port: byte/word/long commands to long-address accesses.
// Latency: 3 cycles req->done with ena_bus high; long-read bursts return 1 long per 2 cycles.
// Backpressure: req is taken only in IDLE (ignored while busy); ISSUE stalls until ena_bus is high.
module hub_xfer (
    input  logic        clk_cog,
    input  logic        res,
    input  logic        ena_bus,
    input  logic        req,
    input  logic        cmd_w,
    input  logic [1:0]  cmd_sz,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_d,
    input  logic [3:0]  cmd_len,
    output logic        busy,
    output logic        done,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        w,
    output logic [3:0]  wb,
    output logic [13:0] a,
    output logic [31:0] d,
    input  logic [31:0] q
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  lane;
    logic [1:0]  sz;
    logic        wr;
    logic [3:0]  beats;
    logic [3:0]  wb_steer;
    logic [31:0] d_steer;
    logic [31:0] rd_sel;

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (req)     state_nxt = S_ISSUE;
            S_ISSUE:   if (ena_bus) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = (beats != 4'd0) ? S_ISSUE : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // Write lane steering; size 11 behaves as long.
    always_comb begin
        wb_steer = 4'b1111;
        d_steer  = cmd_d;
        case (cmd_sz)
            2'b00: begin
                wb_steer = 4'b0001 << cmd_addr[1:0];
                d_steer  = {4{cmd_d[7:0]}};
            end
            2'b01: begin
                wb_steer = cmd_addr[1] ? 4'b1100 : 4'b0011;
                d_steer  = {2{cmd_d[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_sel = q;
        case (sz)
            2'b00: begin
                case (lane)
                    2'd0:    rd_sel = {24'b0, q[7:0]};
                    2'd1:    rd_sel = {24'b0, q[15:8]};
                    2'd2:    rd_sel = {24'b0, q[23:16]};
                    default: rd_sel = {24'b0, q[31:24]};
                endcase
            end
            2'b01:   rd_sel = {16'b0, (lane[1] ? q[31:16] : q[15:0])};
            default: ;
        endcase
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            lane     <= 2'd0;
            sz       <= 2'd0;
            wr       <= 1'b0;
            beats    <= 4'd0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 32'h0;
            w        <= 1'b0;
            wb       <= 4'h0;
            a        <= 14'h0;
            d        <= 32'h0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        a     <= cmd_addr[15:2];
                        lane  <= cmd_addr[1:0];
                        sz    <= cmd_sz;
                        wr    <= cmd_w;
                        beats <= (!cmd_w && cmd_sz[1]) ? cmd_len : 4'd0;
                        w     <= cmd_w;
                        wb    <= cmd_w ? wb_steer : 4'h0;
                        d     <= cmd_w ? d_steer : 32'h0;
                    end
                end
                S_ISSUE: begin
                    // Drop the strobes on the sampling edge so the write is single-shot.
                    if (ena_bus) begin
                        w  <= 1'b0;
                        wb <= 4'h0;
                    end
                end
                S_CAPTURE: begin
                    if (!wr) begin
                        rd_valid <= 1'b1;
                        rd_data  <= rd_sel;
                    end
                    if (beats != 4'd0) begin
                        beats <= beats - 4'd1;
                        a     <= a + 14'd1;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hub_xfer.sv
// Directed bench for hub_xfer with a behavioural hub memory (upper half read-only).
module tb_hub_xfer;

    logic        clk_cog = 1'b0;
    logic        res;
    logic        ena_bus;
    logic        req;
    logic        cmd_w;
    logic [1:0]  cmd_sz;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_d;
    logic [3:0]  cmd_len;
    logic        busy, done, rd_valid, w;
    logic [31:0] rd_data, d, q;
    logic [3:0]  wb;
    logic [13:0] a;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:16383];
    logic [31:0] rdq [$];
    logic [13:0] aq  [$];
    logic        issue_w, issue_busy, rv_at_done;
    logic [3:0]  issue_wb;
    logic [13:0] issue_a;
    logic [31:0] issue_d;
    int          cyc;

    hub_xfer dut (
        .clk_cog(clk_cog), .res(res), .ena_bus(ena_bus), .req(req),
        .cmd_w(cmd_w), .cmd_sz(cmd_sz), .cmd_addr(cmd_addr), .cmd_d(cmd_d),
        .cmd_len(cmd_len), .busy(busy), .done(done), .rd_valid(rd_valid),
        .rd_data(rd_data), .w(w), .wb(wb), .a(a), .d(d), .q(q)
    );

    always #5 clk_cog = ~clk_cog;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = {16'hC0DE, 2'b00, 14'(i)};
    end

    always @(posedge clk_cog) begin
        if (ena_bus) begin
            if (w && !a[13])
                for (int b = 0; b < 4; b++)
                    if (wb[b]) mem[a][8*b +: 8] <= d[8*b +: 8];
            q <= mem[a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic wr, input logic [1:0] sz, input logic [15:0] addr,
                           input logic [31:0] dat, input logic [3:0] len, input bit tog,
                           output int cycles);
        bit seen;
        seen = 0;
        cycles = 0;
        rv_at_done = 0;
        rdq.delete();
        aq.delete();
        req = 1; cmd_w = wr; cmd_sz = sz; cmd_addr = addr; cmd_d = dat; cmd_len = len;
        ena_bus = 1;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk_cog);
            if (k == 1) begin
                issue_w = w; issue_wb = wb; issue_a = a; issue_d = d; issue_busy = busy;
            end
            if (busy && (aq.size() == 0 || aq[$] != a)) aq.push_back(a);
            if (rd_valid) rdq.push_back(rd_data);
            if (done) begin
                seen = 1;
                cycles = k;
                rv_at_done = rd_valid;
            end
            req = 0;
            if (tog) ena_bus = ~ena_bus;
        end
        chk("cmd_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        res = 1; ena_bus = 0; req = 0; cmd_w = 0; cmd_sz = 0;
        cmd_addr = 0; cmd_d = 0; cmd_len = 0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rv", 32'(rd_valid), 0);
        chk("rst_w", 32'(w), 0);
        chk("rst_wb", 32'(wb), 0);
        chk("rst_a", 32'(a), 0);
        chk("rst_d", d, 0);
        chk("rst_rdata", rd_data, 0);
        @(negedge clk_cog);
        res = 0;
        @(negedge clk_cog);

        // Long write $DEADBEEF to $0104
        run_cmd(1, 2'b10, 16'h0104, 32'hDEADBEEF, 4'd5, 0, cyc);
        chk("lw_busy", 32'(issue_busy), 1);
        chk("lw_w", 32'(issue_w), 1);
        chk("lw_wb", 32'(issue_wb), 32'hF);
        chk("lw_a", 32'(issue_a), 32'h0041);
        chk("lw_d", issue_d, 32'hDEADBEEF);
        chk("lw_lat", cyc, 3);
        chk("lw_busy_end", 32'(busy), 0);
        chk("lw_no_rv", rdq.size(), 0);

        // Byte write $5A to $0107, then reads
        run_cmd(1, 2'b00, 16'h0107, 32'h0000005A, 4'd0, 0, cyc);
        chk("bw_wb", 32'(issue_wb), 32'h8);
        chk("bw_d", issue_d, 32'h5A5A5A5A);
        run_cmd(0, 2'b00, 16'h0107, 32'h0, 4'd0, 0, cyc);
        chk("br_data", rdq.size() == 1 ? rdq[0] : 32'hX, 32'h0000005A);
        chk("br_rd_wb", 32'(issue_wb), 0);
        chk("br_rv_done", 32'(rv_at_done), 1);
        run_cmd(0, 2'b10, 16'h0104, 32'h0, 4'd0, 0, cyc);
        chk("lr_data", rdq.size() == 1 ? rdq[0] : 32'hX, 32'h5AADBEEF);
        chk("lr_lat", cyc, 3);

        // Word reads against $12345678
        run_cmd(1, 2'b10, 16'h0104, 32'h12345678, 4'd0, 0, cyc);
        run_cmd(0, 2'b01, 16'h0106, 32'h0, 4'd0, 0, cyc);
        chk("wr_hi", rdq.size() == 1 ? rdq[0] : 32'hX, 32'h00001234);
        run_cmd(0, 2'b01, 16'h0105, 32'h0, 4'd0, 0, cyc);
        chk("wr_lo", rdq.size() == 1 ? rdq[0] : 32'hX, 32'h00005678);

        // Long burst of 4 from $FFF8 with ena_bus toggling, wraps $3FFF -> $0000
        run_cmd(0, 2'b10, 16'hFFF8, 32'h0, 4'd3, 1, cyc);
        chk("bu_na", aq.size(), 4);
        if (aq.size() == 4) begin
            chk("bu_a0", 32'(aq[0]), 32'h3FFE);
            chk("bu_a1", 32'(aq[1]), 32'h3FFF);
            chk("bu_a2", 32'(aq[2]), 32'h0000);
            chk("bu_a3", 32'(aq[3]), 32'h0001);
        end
        chk("bu_nrv", rdq.size(), 4);
        if (rdq.size() == 4) begin
            chk("bu_d0", rdq[0], 32'hC0DE3FFE);
            chk("bu_d1", rdq[1], 32'hC0DE3FFF);
            chk("bu_d2", rdq[2], 32'hC0DE0000);
            chk("bu_d3", rdq[3], 32'hC0DE0001);
        end
        chk("bu_rv_done", 32'(rv_at_done), 1);
        chk("bu_lat", cyc, 10);

        // ROM write is discarded
        run_cmd(1, 2'b10, 16'h8000, 32'h11223344, 4'd0, 0, cyc);
        chk("rom_lat", cyc, 3);
        chk("rom_a", 32'(issue_a), 32'h2000);
        run_cmd(0, 2'b10, 16'h8000, 32'h0, 4'd0, 0, cyc);
        chk("rom_rd", rdq.size() == 1 ? rdq[0] : 32'hX, 32'hC0DE2000);

        // Reset while stalled in ISSUE
        @(negedge clk_cog);
        req = 1; cmd_w = 1; cmd_sz = 2'b10; cmd_addr = 16'h0104; cmd_d = 32'hFFFFFFFF;
        ena_bus = 0;
        @(negedge clk_cog);
        req = 0;
        chk("mid_busy", 32'(busy), 1);
        chk("mid_w", 32'(w), 1);
        #1 res = 1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_w", 32'(w), 0);
        chk("mr_wb", 32'(wb), 0);
        chk("mr_a", 32'(a), 0);
        chk("mr_d", d, 0);
        ena_bus = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_cog);
            chk("mr_no_done", 32'(done), 0);
        end
        res = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_cog);
            chk("post_no_done", 32'(done), 0);
        end
        run_cmd(0, 2'b00, 16'h0107, 32'h0, 4'd0, 0, cyc);
        chk("post_rd", rdq.size() == 1 ? rdq[0] : 32'hX, 32'h00000012);
        chk("post_lat", cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
